// File: rtl/mux_seq_pkg.sv
// Shared widths and FSM state type for the mux select sequencer.
package mux_seq_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage : mux_seq_pkg

// File: rtl/mux_sel_sequencer_if.sv
// Request/grant bundle between the sources/consumer (master) and the sequencer (slave).
interface mux_sel_sequencer_if;
    import mux_seq_pkg::*;

    logic [NUM_CH-1:0] req;
    logic              done;
    logic              s1;
    logic              s0;
    logic [NUM_CH-1:0] gnt;
    logic              valid;
    logic              timeout;

    modport master (
        output req, done,
        input  s1, s0, gnt, valid, timeout
    );

    modport slave (
        input  req, done,
        output s1, s0, gnt, valid, timeout
    );

endinterface : mux_sel_sequencer_if

// File: rtl/mux_sel_sequencer_rr_pick.sv
// Combinational rotating-priority picker: first requester after ptr, ptr itself last.
module rr_pick
    import mux_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    logic [SEL_W-1:0] cand;

    // Walk from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        idx  = '0;
        cand = '0;
        any  = |req;
        for (int k = int'(NUM_CH); k >= 1; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule : rr_pick

// File: rtl/mux_sel_sequencer.sv
// Round-robin 4:1 mux select sequencer with registered select/grant outputs.
// Optional dwell timeout enabled by defining MUX_SEQ_TIMEOUT_EN.
module mux_sel_sequencer
    import mux_seq_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_sel_sequencer_if.slave    bus
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_chk
        $error("HOLD_MAX out of range 2..255");
    end

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic              valid_q, valid_d;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;
    logic              hold_drop_c;
    logic              force_rel_c;

    rr_pick u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign hold_drop_c = bus.done | ~bus.req[sel_q];

`ifdef MUX_SEQ_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // cnt_q counts completed grant cycles; the last allowed cycle is HOLD_MAX-1.
    assign force_rel_c = (cnt_q == CNT_W'(HOLD_MAX - 1));
    assign bus.timeout = timeout_q;
`else
    assign force_rel_c = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.s1    = sel_q[1];
    assign bus.s0    = sel_q[0];
    assign bus.gnt   = gnt_q;
    assign bus.valid = valid_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
`ifdef MUX_SEQ_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = NUM_CH'(1) << pick_idx;
                    valid_d = 1'b1;
`ifdef MUX_SEQ_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                // A consumer/requester release outranks the forced one.
                if (hold_drop_c || force_rel_c) begin
                    state_d = IDLE;
                    ptr_d   = sel_q;
                    gnt_d   = '0;
                    valid_d = 1'b0;
`ifdef MUX_SEQ_TIMEOUT_EN
                    timeout_d = ~hold_drop_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= SEL_W'(NUM_CH - 1);
            gnt_q   <= '0;
            valid_q <= 1'b0;
`ifdef MUX_SEQ_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
`ifdef MUX_SEQ_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

endmodule : mux_sel_sequencer
